// File: rtl/cgu_unit.sv
// rtl/cgu_unit.sv - carry generate unit with registered carry and carry event counter
//
// Purpose: computes cout = gout | (pout & cin) for one lookahead position.
// It also provides a registered copy of the carry and a saturating count of
// carry events, used when debugging adder chains.
//
// Optional feature macro: CGU_CNT_EN
//   defined   : carry event counter implemented
//   undefined : carry_cnt tied to 0, cnt_clr ignored, no counter flops
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   pout      in   propagate from the PG stage
//   cin       in   carry-in to this position
//   gout      in   generate from the PG stage
//   cout      out  combinational carry-out; valid during reset
//   cout_q    out  cout registered on clk
//   cnt_clr   in   synchronous counter clear; wins over the increment
//   carry_cnt out  saturating count of edges with cout=1 (CNT_W bits)

module cgu_unit #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pout,
    input  logic             cin,
    input  logic             gout,
    output logic             cout,
    output logic             cout_q,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] carry_cnt
);

    // Plain gate expression so X/Z propagate with normal gate semantics.
    assign cout = gout | (pout & cin);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cout_q <= 1'b0;
        end else begin
            cout_q <= cout;
        end
    end

`ifdef CGU_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear beats increment; the all-ones value holds instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cout && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign carry_cnt = cnt_q;
`else
    // The counter is absent. cnt_clr is masked to keep it referenced, so the
    // output is constant zero.
    assign carry_cnt = {CNT_W{cnt_clr & 1'b0}};
`endif

endmodule

// File: tb/tb_cgu_unit.sv
// tb/tb_cgu_unit.sv - self-checking bench for cgu_unit with a reference model

module tb_cgu_unit;

`ifdef CGU_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pout = 1'b0;
    logic       cin = 1'b0;
    logic       gout = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       cout8, cout_q8;
    logic       cout3, cout_q3;
    logic [7:0] cnt8;
    logic [2:0] cnt3;

    int errors = 0;
    int checks = 0;

    // Truth table indexed by {cin,pout,gout}. Bit i holds the carry-out for pattern i.
    logic [7:0] tbl = 8'b1110_1010;

    // Reference model state.
    bit m_q;
    int m8;
    int m3;

    always #5 clk = ~clk;

    cgu_unit #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .pout(pout), .cin(cin), .gout(gout),
        .cout(cout8), .cout_q(cout_q8), .cnt_clr(cnt_clr), .carry_cnt(cnt8)
    );

    cgu_unit #(.CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .pout(pout), .cin(cin), .gout(gout),
        .cout(cout3), .cout_q(cout_q3), .cnt_clr(cnt_clr), .carry_cnt(cnt3)
    );

    function automatic int exp8();
        return CNT_EN ? m8 : 0;
    endfunction

    function automatic int exp3();
        return CNT_EN ? m3 : 0;
    endfunction

    // Advance one clock edge and update the model. Returns 1 time unit after the edge.
    task automatic tick();
        bit e;
        e = tbl[{cin, pout, gout}];
        @(posedge clk);
        if (rst) begin
            m_q = 1'b0; m8 = 0; m3 = 0;
        end else begin
            m_q = e;
            if (cnt_clr) begin
                m8 = 0; m3 = 0;
            end else if (e) begin
                if (m8 < 255) m8 = m8 + 1;
                if (m3 < 7) m3 = m3 + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (cout_q8 !== 1'b0) begin errors++; $display("FAIL reset_cout_q got=%b exp=0", cout_q8); end
        checks++;
        if (cnt8 !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt8); end
        {cin, pout, gout} = 3'b111;
        tick();
        checks++;
        if (cout8 !== 1'b1) begin errors++; $display("FAIL reset_cout111 got=%b exp=1", cout8); end
        checks++;
        if (cout_q8 !== 1'b0) begin errors++; $display("FAIL reset_hold_cout_q got=%b exp=0", cout_q8); end
        checks++;
        if (cnt8 !== 8'd0) begin errors++; $display("FAIL reset_hold_cnt got=%0d exp=0", cnt8); end
    endtask

    task automatic test_truth_sweep();
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            {cin, pout, gout} = v;
            #1;
            checks++;
            if (cout8 !== tbl[i]) begin
                errors++; $display("FAIL truth_%0d got=%b exp=%b", i, cout8, tbl[i]);
            end
            checks++;
            if (cout3 !== tbl[i]) begin
                errors++; $display("FAIL truth3_%0d got=%b exp=%b", i, cout3, tbl[i]);
            end
        end
    endtask

    task automatic test_gen_run();
        {cin, pout, gout} = 3'b001;
        cnt_clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (cout_q8 !== 1'b1) begin errors++; $display("FAIL gen_cout_q_%0d got=%b exp=1", i, cout_q8); end
        end
        checks++;
        if (int'(cnt8) != (CNT_EN ? 5 : 0)) begin
            errors++; $display("FAIL gen_cnt got=%0d exp=%0d", cnt8, CNT_EN ? 5 : 0);
        end
    endtask

    task automatic test_saturate();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        {cin, pout, gout} = 3'b110;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (int'(cnt3) != (CNT_EN ? 7 : 0)) begin
            errors++; $display("FAIL sat_cnt3 got=%0d exp=%0d", cnt3, CNT_EN ? 7 : 0);
        end
        checks++;
        if (int'(cnt8) != (CNT_EN ? 10 : 0)) begin
            errors++; $display("FAIL sat_cnt8 got=%0d exp=%0d", cnt8, CNT_EN ? 10 : 0);
        end
    endtask

    task automatic test_clr_priority();
        {cin, pout, gout} = 3'b001;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        checks++;
        if (cnt8 !== 8'd0) begin errors++; $display("FAIL clr_prio_cnt8 got=%0d exp=0", cnt8); end
        checks++;
        if (cnt3 !== 3'd0) begin errors++; $display("FAIL clr_prio_cnt3 got=%0d exp=0", cnt3); end
        checks++;
        if (cout_q8 !== 1'b1) begin errors++; $display("FAIL clr_prio_cout_q got=%b exp=1", cout_q8); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic [2:0] v;
            v = 3'($urandom_range(0, 7));
            {cin, pout, gout} = v;
            cnt_clr = ($urandom_range(0, 29) == 0);
            #1;
            checks++;
            if (cout8 !== tbl[v]) begin errors++; $display("FAIL rnd_cout_%0d got=%b exp=%b", i, cout8, tbl[v]); end
            tick();
            checks++;
            if (cout_q8 !== m_q) begin errors++; $display("FAIL rnd_cout_q_%0d got=%b exp=%b", i, cout_q8, m_q); end
            checks++;
            if (int'(cnt8) != exp8()) begin errors++; $display("FAIL rnd_cnt8_%0d got=%0d exp=%0d", i, cnt8, exp8()); end
            checks++;
            if (int'(cnt3) != exp3()) begin errors++; $display("FAIL rnd_cnt3_%0d got=%0d exp=%0d", i, cnt3, exp3()); end
            if ($urandom_range(0, 39) == 0) begin
                // Async reset mid-cycle must clear the registers before any edge.
                rst = 1'b1;
                #1;
                m_q = 1'b0; m8 = 0; m3 = 0;
                checks++;
                if (cout_q8 !== 1'b0 || cnt8 !== 8'd0 || cnt3 !== 3'd0) begin
                    errors++; $display("FAIL rnd_async_rst_%0d got q=%b c8=%0d c3=%0d exp 0", i, cout_q8, cnt8, cnt3);
                end
                checks++;
                if (cout8 !== tbl[v]) begin errors++; $display("FAIL rnd_rst_cout_%0d got=%b exp=%b", i, cout8, tbl[v]); end
                #1;
                rst = 1'b0;
            end
        end
    endtask

    initial begin
        m_q = 1'b0; m8 = 0; m3 = 0;
        test_truth_sweep();
        test_reset();
        test_gen_run();
        test_saturate();
        test_clr_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
